// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO controllers.
// Holds the Gray/binary pointer helpers, the pointer-width constants and the
// elastic-buffer state encoding. The helpers work on a fixed 32-bit word so
// that both read and write controllers can use them for any depth; callers
// zero-extend their pointer on the way in and truncate on the way out.
package fifo_pkg;

    // Widest pointer the helpers handle.
    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Elastic-buffer occupancy.
    // Bit 0 is the head-valid flag and bit 1 is the skid-valid flag, so
    // rd_valid comes straight off a flop. 2'b10 (skid without head) is illegal.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b11
    } buf_state_e;

    // Pointer width for a given memory depth: one extra bit tells full from empty.
    function automatic int unsigned ptr_width(input int unsigned num_address);
        return $clog2(num_address) + 1;
    endfunction

    // Binary to Gray: adjacent values differ in exactly one bit.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry elastic buffer between the FIFO memory read port and the consumer.
// The memory returns data one cycle after the read strobe. This buffer tracks
// that in-flight read, captures the word into the head (or the skid when the
// head is occupied and not being popped), and reports occupancy, so the issue
// logic can keep reading one word per cycle without overrunning two slots.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   r_clk,
    input  logic                   reset,
    input  logic                   i_issue,
    input  logic [DATA_LENGTH-1:0] i_mem_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DATA_LENGTH-1:0] o_data,
    output logic [1:0]             o_occ,
    output logic                   o_pop
);

    buf_state_e             r_state;
    buf_state_e             w_next_state;
    logic                   r_in_flight;
    logic [DATA_LENGTH-1:0] r_head;
    logic [DATA_LENGTH-1:0] r_skid;

    logic                   w_pop;
    logic                   w_load_head;
    logic                   w_head_from_skid;
    logic                   w_load_skid;

    assign o_valid = r_state[0];
    assign o_data  = r_head;
    assign w_pop   = r_state[0] & i_ready;
    assign o_pop   = w_pop;

    // Buffered words plus the read whose data arrives at the next edge.
    assign o_occ = {1'b0, r_state[0]} + {1'b0, r_state[1]} + {1'b0, r_in_flight};

    // Buffer state register.
    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In-flight flag: the memory presents data one edge after a strobe.
    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= i_issue;
        end
    end

    // Next buffer state and data-move strobes; the head always holds the oldest word.
    always_comb begin
        w_next_state     = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (r_in_flight) begin
                    w_load_head  = 1'b1;
                    w_next_state = BUF_ONE;
                end else begin
                    w_next_state = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (w_pop) begin
                    if (r_in_flight) begin
                        w_load_head  = 1'b1;
                        w_next_state = BUF_ONE;
                    end else begin
                        w_next_state = BUF_EMPTY;
                    end
                end else begin
                    if (r_in_flight) begin
                        w_load_skid  = 1'b1;
                        w_next_state = BUF_TWO;
                    end else begin
                        w_next_state = BUF_ONE;
                    end
                end
            end
            BUF_TWO: begin
                // The issue logic never reads while both slots are held
                // unpopped, so a capture here always coincides with a pop.
                if (w_pop) begin
                    w_head_from_skid = 1'b1;
                    if (r_in_flight) begin
                        w_load_skid  = 1'b1;
                        w_next_state = BUF_TWO;
                    end else begin
                        w_next_state = BUF_ONE;
                    end
                end else begin
                    w_next_state = BUF_TWO;
                end
            end
            default: begin
                w_next_state = BUF_EMPTY;
            end
        endcase
    end

    // Head and skid data registers; the head only changes on capture or pop,
    // so rd_data stays stable while the consumer stalls.
    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_head <= {DATA_LENGTH{1'b0}};
            r_skid <= {DATA_LENGTH{1'b0}};
        end else begin
            if (w_load_head) begin
                r_head <= i_mem_data;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end else begin
                r_head <= r_head;
            end
            if (w_load_skid) begin
                r_skid <= i_mem_data;
            end else begin
                r_skid <= r_skid;
            end
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the dual-clock FIFO.
// Owns the binary read pointer, the registered empty flag and the read-issue
// decision; data is handed to the consumer through fifo_rd_skid.
// Optional feature macro: FIFO_RD_LEVEL_EN adds the registered rd_level output
// (words in memory not yet read). NUM_ADDRESS must be a power of two, >= 2.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter  int NUM_ADDRESS = 8,
    parameter  int DATA_LENGTH = 32,
    localparam int ADDR_WIDTH  = $clog2(NUM_ADDRESS)
) (
    input  logic                   r_clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH:0]    w_gray_ptr_sync,
    input  logic [DATA_LENGTH-1:0] read_data_out,
    output logic                   read_enable,
    output logic [ADDR_WIDTH-1:0]  read_address,
    output logic [ADDR_WIDTH:0]    r_gray_ptr,
    output logic                   empty,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_LENGTH-1:0] rd_data
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]    rd_level
`endif
);

    localparam int PTR_W = ptr_width(NUM_ADDRESS);

    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_rgray;
    logic             r_empty;

    logic [PTR_W-1:0] w_rptr_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [1:0]       w_occ;
    logic [1:0]       w_occ_after_pop;
    logic             w_pop;
    logic             w_read_enable;

    // Issue a read only when memory has data and the buffer can absorb it,
    // counting a word popped this cycle as already gone.
    assign w_occ_after_pop = w_occ - {1'b0, w_pop};
    assign w_read_enable   = (~r_empty) & (w_occ_after_pop < 2'd2);

    // Empty and the published Gray pointer look at the post-increment pointer,
    // so the word being read this cycle is never counted as still available.
    assign w_rptr_next = r_rptr + {{ADDR_WIDTH{1'b0}}, w_read_enable};
    assign w_gray_next = PTR_W'(bin2gray(ptr_word_t'(w_rptr_next)));

    assign read_enable  = w_read_enable;
    assign read_address = r_rptr[ADDR_WIDTH-1:0];
    assign r_gray_ptr   = r_rgray;
    assign empty        = r_empty;

    // Read pointer, Gray pointer and empty flag.
    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_rptr  <= {PTR_W{1'b0}};
            r_rgray <= {PTR_W{1'b0}};
            r_empty <= 1'b1;
        end else begin
            r_rptr  <= w_rptr_next;
            r_rgray <= w_gray_next;
            r_empty <= (w_gray_next == w_gray_ptr_sync);
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_W-1:0] w_wptr_bin;
    logic [PTR_W-1:0] r_rd_level;

    assign w_wptr_bin = PTR_W'(gray2bin(ptr_word_t'(w_gray_ptr_sync)));
    assign rd_level   = r_rd_level;

    // Unread words in memory, modulo the pointer range.
    always_ff @(posedge r_clk) begin
        if (reset) begin
            r_rd_level <= {PTR_W{1'b0}};
        end else begin
            r_rd_level <= w_wptr_bin - w_rptr_next;
        end
    end
`else
    // Level tracking is not built in this configuration.
`endif

    fifo_rd_skid #(
        .DATA_LENGTH (DATA_LENGTH)
    ) u_skid (
        .r_clk      (r_clk),
        .reset      (reset),
        .i_issue    (w_read_enable),
        .i_mem_data (read_data_out),
        .i_ready    (rd_ready),
        .o_valid    (rd_valid),
        .o_data     (rd_data),
        .o_occ      (w_occ),
        .o_pop      (w_pop)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: models the memory and the write side,
// collects popped words at the falling edge and checks against hand values.
module tb_fifo_read_ctrl;

    logic        r_clk = 1'b0;
    logic        reset;
    logic [3:0]  w_gray_ptr_sync;
    logic [31:0] read_data_out = 32'd0;
    logic        read_enable;
    logic [2:0]  read_address;
    logic [3:0]  r_gray_ptr;
    logic        empty;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0]  rd_level;
`endif

    logic [31:0] mem [8];
    logic [3:0]  wptr;
    logic [31:0] got_q [$];
    int          n_reads = 0;
    int          run     = 0;
    int          max_run = 0;
    int          n_total = 0;
    int          n_bad   = 0;
    int          base;
    int          reads0;

    fifo_read_ctrl #(.NUM_ADDRESS(8), .DATA_LENGTH(32)) dut (
        .r_clk           (r_clk),
        .reset           (reset),
        .w_gray_ptr_sync (w_gray_ptr_sync),
        .read_data_out   (read_data_out),
        .read_enable     (read_enable),
        .read_address    (read_address),
        .r_gray_ptr      (r_gray_ptr),
        .empty           (empty),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level        (rd_level)
`endif
    );

    always #5 r_clk = ~r_clk;

    // Memory read port: one-cycle registered read.
    always @(posedge r_clk) begin
        if (read_enable) read_data_out <= mem[read_address];
    end

    // Consumer-side monitor.
    always @(negedge r_clk) begin
        if (rd_valid && rd_ready) got_q.push_back(rd_data);
        if (read_enable) n_reads = n_reads + 1;
        if (rd_valid) run = run + 1;
        else run = 0;
        if (run > max_run) max_run = run;
    end

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        mem[wptr[2:0]] = d;
        wptr = wptr + 4'd1;
        w_gray_ptr_sync = g4(wptr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wptr = 4'd0;
        w_gray_ptr_sync = 4'd0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        rd_ready = 1'b0;
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_valid", rd_valid, 0);
        chk("rst_rden", read_enable, 0);
        chk("rst_gray", r_gray_ptr, 0);
        chk("rst_addr", read_address, 0);
        chk("rst_data", rd_data, 0);
        tick(3);
        chk("idle_empty", empty, 1);
        chk("idle_rden", read_enable, 0);

        // Single word
        base = got_q.size();
        push(32'hA5A5A5A5);
        tick(1);
        chk("single_rden", read_enable, 1);
        chk("single_addr", read_address, 0);
        chk("single_empty0", empty, 0);
        tick(1);
        chk("single_rden_off", read_enable, 0);
        chk("single_empty1", empty, 1);
        chk("single_gray", r_gray_ptr, 4'b0001);
        chk("single_valid0", rd_valid, 0);
        tick(1);
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 32'hA5A5A5A5);
        rd_ready = 1'b1;
        tick(1);
        chk("single_popped", rd_valid, 0);
        chk("single_cnt", got_q.size(), base + 1);
        if (got_q.size() > base) chk("single_q", got_q[base], 32'hA5A5A5A5);

        // Streaming
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 8; i++) begin
            push(32'hDEADBABE + i);
            tick(1);
        end
        tick(8);
        chk("stream_cnt", got_q.size(), base + 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < got_q.size()) chk("stream_data", got_q[base+i], 32'hDEADBABE + i);
        end
        chk("stream_run", max_run, 8);
        chk("stream_gray", r_gray_ptr, 4'b1100);
        chk("stream_empty", empty, 1);

        // Backpressure
        rd_ready = 1'b0;
        base = got_q.size();
        reads0 = n_reads;
        for (int i = 0; i < 4; i++) begin
            push(32'h10000000 + i);
            tick(1);
        end
        tick(6);
        chk("bp_reads", n_reads - reads0, 2);
        chk("bp_valid", rd_valid, 1);
        chk("bp_data", rd_data, 32'h10000000);
        tick(3);
        chk("bp_hold", rd_data, 32'h10000000);
        chk("bp_reads2", n_reads - reads0, 2);
        rd_ready = 1'b1;
        tick(10);
        chk("bp_cnt", got_q.size(), base + 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < got_q.size()) chk("bp_order", got_q[base+i], 32'h10000000 + i);
        end
        chk("bp_reads_all", n_reads - reads0, 4);
        chk("bp_empty", empty, 1);

        // Wrap-around
        do_reset();
        base = got_q.size();
        for (int i = 0; i < 20; i++) begin
            push(32'hC0DE0000 + i);
            tick(1);
        end
        tick(8);
        chk("wrap_cnt", got_q.size(), base + 20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < got_q.size()) chk("wrap_data", got_q[base+i], 32'hC0DE0000 + i);
        end
        chk("wrap_gray", r_gray_ptr, 4'b0110);
        chk("wrap_addr", read_address, 3'd4);
        chk("wrap_empty", empty, 1);

        // Reset mid-stream with both buffer slots full
        rd_ready = 1'b0;
        do_reset();
        mem[0] = 32'h5A5A0000;
        mem[1] = 32'h5A5A0001;
        mem[2] = 32'h5A5A0002;
        wptr = 4'd3;
        w_gray_ptr_sync = g4(4'd3);
        tick(1);
        chk("mid_empty0", empty, 0);
`ifdef FIFO_RD_LEVEL_EN
        chk("mid_level3", rd_level, 3);
`endif
        tick(4);
        chk("mid_valid", rd_valid, 1);
        chk("mid_data", rd_data, 32'h5A5A0000);
        chk("mid_rden_full", read_enable, 0);
`ifdef FIFO_RD_LEVEL_EN
        chk("mid_level1", rd_level, 1);
`endif
        reset = 1'b1;
        wptr = 4'd0;
        w_gray_ptr_sync = 4'd0;
        tick(1);
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_addr", read_address, 0);
        chk("mid_rst_gray", r_gray_ptr, 0);
        chk("mid_rst_rden", read_enable, 0);
        chk("mid_rst_data", rd_data, 0);
`ifdef FIFO_RD_LEVEL_EN
        chk("mid_rst_level", rd_level, 0);
`endif
        reset = 1'b0;
        tick(3);
        chk("mid_after_empty", empty, 1);
        chk("mid_after_valid", rd_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
